// File: rtl/reload_scheduler.sv
// rtl/reload_scheduler.sv - round-robin owner scheduler for one shared self-reloading up-counter
module reload_scheduler #(
    parameter int N_REQ             = 4,
    parameter int WIDTH             = 4,
    parameter int PERIODS_PER_GRANT = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*WIDTH-1:0] req_val_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [N_REQ-1:0]       done_o,
    output logic                   busy_o,
    output logic                   ctr_load_o,
    output logic [WIDTH-1:0]       ctr_load_val_o,
    input  logic [WIDTH-1:0]       ctr_count_i
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW = (PERIODS_PER_GRANT > 1) ? $clog2(PERIODS_PER_GRANT) : 1;
    localparam logic [PW-1:0]    LAST_PERIOD = PW'(PERIODS_PER_GRANT - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0    = N_REQ'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RUN     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   last_owner;
    logic [PW-1:0]   period_cnt;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand_idx;
    logic [WIDTH-1:0] win_val;

    // Search upward from the requester after the previous owner, wrapping at N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand_idx = IW'((int'(last_owner) + i) % N_REQ);
            if (!win_found && req_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign win_val = req_val_i[win_idx*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            owner          <= '0;
            last_owner     <= IW'(N_REQ - 1);
            period_cnt     <= '0;
            gnt_o          <= '0;
            done_o         <= '0;
            busy_o         <= 1'b0;
            ctr_load_o     <= 1'b0;
            ctr_load_val_o <= '0;
        end else begin
            done_o <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        owner          <= win_idx;
                        gnt_o          <= ONE_HOT0 << win_idx;
                        ctr_load_o     <= 1'b1;
                        ctr_load_val_o <= win_val;
                        busy_o         <= 1'b1;
                        state          <= LOAD;
                    end
                end
                LOAD: begin
                    ctr_load_o <= 1'b0;
                    period_cnt <= '0;
                    state      <= RUN;
                end
                RUN: begin
                    // A withdrawn request wins over a period end on the same cycle.
                    if (!req_i[owner]) begin
                        gnt_o  <= '0;
                        busy_o <= 1'b0;
                        state  <= RELEASE;
                    end else if (ctr_count_i == '1) begin
                        done_o     <= gnt_o;
                        period_cnt <= period_cnt + 1'b1;
                        if (period_cnt == LAST_PERIOD) begin
                            gnt_o  <= '0;
                            busy_o <= 1'b0;
                            state  <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    last_owner <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reload_scheduler.sv
// tb/tb_reload_scheduler.sv - scoreboard bench for reload_scheduler with an external counter model
module tb_reload_scheduler;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int PPG = 2;

    localparam int EV_LOAD = 0;
    localparam int EV_DONE = 1;
    localparam int EV_REL  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_i = '0;
    logic [N*W-1:0]   req_val = '0;
    logic [N*W-1:0]   pend_val = '0;
    logic [N-1:0]     gnt_o;
    logic [N-1:0]     done_o;
    logic             busy_o;
    logic             ctr_load_o;
    logic [W-1:0]     ctr_load_val_o;
    logic [W-1:0]     ctr_count = '0;
    logic [W-1:0]     ctr_reload = '0;

    int checks = 0;
    int failures = 0;
    int model_last = N - 1;
    bit mon_en = 1'b0;
    int cyc = 0;
    int last_ev_cyc = 0;
    logic busy_prev = 1'b0;

    typedef struct {
        int           kind;
        logic [N-1:0] vec;
        logic [W-1:0] val;
        int           gap;
    } ev_t;

    ev_t exp_q[$];

    reload_scheduler #(.N_REQ(N), .WIDTH(W), .PERIODS_PER_GRANT(PPG)) dut (
        .clk            (clk),
        .reset          (rst_n),
        .req_i          (req_i),
        .req_val_i      (req_val),
        .gnt_o          (gnt_o),
        .done_o         (done_o),
        .busy_o         (busy_o),
        .ctr_load_o     (ctr_load_o),
        .ctr_load_val_o (ctr_load_val_o),
        .ctr_count_i    (ctr_count)
    );

    always #5 clk = ~clk;

    // External counter: loads on load, otherwise counts up and reloads its last loaded value after all-ones.
    always @(posedge clk) begin
        if (ctr_load_o) begin
            ctr_count  <= ctr_load_val_o;
            ctr_reload <= ctr_load_val_o;
        end else if (ctr_count == '1) begin
            ctr_count <= ctr_reload;
        end else begin
            ctr_count <= ctr_count + 1'b1;
        end
    end

    function automatic logic [N-1:0] onehot(input int w);
        onehot = N'(1) << w;
    endfunction

    function automatic int arbitrate(input logic [N-1:0] m, input int lo);
        int k;
        for (int i = 1; i <= N; i++) begin
            k = (lo + i) % N;
            if (((m >> k) & N'(1)) != '0) return k;
        end
        return -1;
    endfunction

    function automatic logic [N*W-1:0] rand_vals();
        rand_vals = (N*W)'({$urandom(), $urandom()});
    endfunction

    task automatic push_ev(input int kind, input logic [N-1:0] vec, input logic [W-1:0] val, input int gap);
        ev_t e;
        e.kind = kind;
        e.vec  = vec;
        e.val  = val;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic handle(input int kind, input logic [N-1:0] vec, input logic [W-1:0] val);
        ev_t e;
        int  gap;
        gap = cyc - last_ev_cyc;
        last_ev_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d vec=%b val=%h cycle=%0d", kind, vec, val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.vec !== vec || (kind == EV_LOAD && e.val !== val) ||
                (e.gap >= 0 && e.gap != gap)) begin
                failures++;
                $display("FAIL scoreboard got kind=%0d vec=%b val=%h gap=%0d required kind=%0d vec=%b val=%h gap=%0d",
                         kind, vec, val, gap, e.kind, e.vec, e.val, e.gap);
            end
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({gnt_o, done_o, busy_o, ctr_load_o, ctr_load_val_o} !== '0) begin
            failures++;
            $display("FAIL %s gnt=%b done=%b busy=%b load=%b load_val=%h required all zero",
                     name, gnt_o, done_o, busy_o, ctr_load_o, ctr_load_val_o);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                checks++;
                if (busy_o !== (gnt_o != '0) || !$onehot0(gnt_o)) begin
                    failures++;
                    $display("FAIL busy_gnt busy=%b gnt=%b required busy equal to one-hot owner present", busy_o, gnt_o);
                end
                if (ctr_load_o === 1'b1) handle(EV_LOAD, gnt_o, ctr_load_val_o);
                if (done_o !== '0) handle(EV_DONE, done_o, '0);
                if (busy_prev === 1'b1 && busy_o === 1'b0) handle(EV_REL, gnt_o, '0);
            end
            busy_prev = busy_o;
        end
    end

    // Entered from an idle cycle; requests in mask are held for the whole scenario.
    task automatic run_held(input logic [N-1:0] mask, input int grants, input int first_gap, input bit chg);
        int w;
        int len;
        logic [W-1:0] v;
        req_i = mask;
        for (int g = 0; g < grants; g++) begin
            w   = arbitrate(mask, model_last);
            v   = W'(req_val >> (w*W));
            len = (1 << W) - int'(v);
            push_ev(EV_LOAD, onehot(w), v, (g == 0) ? first_gap : 2);
            for (int p = 0; p < PPG; p++) push_ev(EV_DONE, onehot(w), '0, (p == 0) ? len + 1 : len);
            push_ev(EV_REL, '0, '0, 0);
            model_last = w;
            step(2);
            if (chg) begin
                req_val  = pend_val;
                pend_val = rand_vals();
            end
            step(PPG*len);
            if (g == grants - 1) begin
                req_i = '0;
                step(2);
            end else begin
                step(1);
            end
        end
    endtask

    // Owner withdraws in RUN cycle j; extra requesters are raised on the first RUN cycle.
    task automatic run_abort(input logic [N-1:0] mask, input logic [N-1:0] extra, input int j_in);
        int w;
        int len;
        int j;
        int prev;
        logic [W-1:0] v;
        logic [N-1:0] m2;
        req_i = mask;
        w   = arbitrate(mask, model_last);
        v   = W'(req_val >> (w*W));
        len = (1 << W) - int'(v);
        j   = (j_in > 0) ? j_in : 1 + $urandom_range(PPG*len - 1, 0);
        push_ev(EV_LOAD, onehot(w), v, -1);
        prev = 0;
        for (int k = 1; k < PPG; k++) begin
            if (k*len < j) begin
                push_ev(EV_DONE, onehot(w), '0, k*len + 1 - prev);
                prev = k*len + 1;
            end
        end
        push_ev(EV_REL, '0, '0, j + 1 - prev);
        model_last = w;
        step(2);
        req_i = mask | extra;
        if (j > 1) step(j - 1);
        m2 = (mask | extra) & ~onehot(w);
        req_i = m2;
        if (m2 != '0) begin
            step(2);
            run_held(m2, 1 + $urandom_range(1, 0), 2, 1'b0);
        end else begin
            step(3);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] m;
        rst_n = 1'b0;
        #1;
        check_zero("reset_init");
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step(2);

        req_val = '0;
        req_val[3:0]   = 4'hC;
        req_val[11:8]  = 4'hE;
        run_held(4'b0101, 4, -1, 1'b0);

        req_val = '0;
        req_val[3:0] = 4'hA;
        run_held(4'b0001, 2, -1, 1'b0);

        req_val[3:0] = 4'hF;
        run_held(4'b0001, 1, -1, 1'b0);

        req_val[3:0]  = 4'hA;
        pend_val      = req_val;
        pend_val[3:0] = 4'h2;
        run_held(4'b0001, 2, -1, 1'b1);

        req_val[7:4]   = 4'h8;
        req_val[15:12] = 4'hD;
        run_abort(4'b0010, 4'b1000, 3);

        mon_en = 1'b0;
        req_val[3:0]   = 4'h5;
        req_val[15:12] = 4'h9;
        req_i = 4'b1001;
        step(6);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("reset_midrun");
        @(posedge clk);
        #1;
        check_zero("reset_held");
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_before_reset got=%0d required=0", exp_q.size());
        end
        exp_q.delete();
        rst_n      = 1'b1;
        model_last = N - 1;
        mon_en     = 1'b1;
        run_held(4'b1001, 2, -1, 1'b0);

        repeat (30) begin
            req_val  = rand_vals();
            pend_val = rand_vals();
            m = N'($urandom_range((1 << N) - 1, 1));
            if ($urandom_range(2, 0) == 0) run_abort(m, N'($urandom()), 0);
            else run_held(m, $urandom_range(3, 1), -1, 1'($urandom_range(1, 0)));
        end

        step(4);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_events got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reload_scheduler.md
Name: reload_scheduler

Overview:
- Shares one external self-reloading up-counter (WIDTH bits, counts up to all-ones, then reloads its last loaded value) among N_REQ requesters.
- Requesters post a reload value. The scheduler grants the counter round-robin and loads the winner's value.
- It reports each completed counter period to the owner and rotates ownership after PERIODS_PER_GRANT periods, or earlier if the owner withdraws its request.
- Sits between the timer clients and the counter's load_i/load_val_i/count_o pins.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 4, counter and reload-value width.
- PERIODS_PER_GRANT, 2, counter periods an owner keeps the counter per grant (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req_i  input  N_REQ  per-requester request level; held until done or withdrawn.
- req_val_i  input  N_REQ*WIDTH  reload values; requester k uses bits [k*WIDTH +: WIDTH].
- gnt_o  output  N_REQ  one-hot current owner; all zero when no owner.
- done_o  output  N_REQ  one-cycle pulse to the owner at each completed period.
- busy_o  output  1  high in LOAD or RUN.
- ctr_load_o  output  1  drives the counter's load_i.
- ctr_load_val_o  output  WIDTH  drives the counter's load_val_i.
- ctr_count_i  input  WIDTH  the counter's count_o.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, reset=0):
  - State=IDLE; gnt_o, done_o, busy_o, ctr_load_o and ctr_load_val_o all 0.
  - Round-robin pointer last_owner=N_REQ-1, so requester 0 has top priority.
  - Period counter=0.
- FSM states: IDLE, LOAD, RUN, RELEASE.
- IDLE:
  - ctr_count_i is ignored.
  - If req_i!=0, the winner is the first set bit searching upward from last_owner+1, modulo N_REQ.
  - Next edge: gnt_o=onehot(winner); capture val=req_val_i[winner]; ctr_load_o=1; ctr_load_val_o=val; go to LOAD.
- LOAD:
  - Exactly one cycle. The counter samples load during this cycle.
  - Next edge: ctr_load_o=0, period_cnt=0, go to RUN.
  - ctr_count_i is ignored in LOAD.
- RUN:
  - ctr_count_i is valid from the first RUN cycle, where it equals val.
  - Period end is any RUN cycle with ctr_count_i == all-ones. The counter reloads itself on the next edge; the scheduler never reasserts load.
  - At a period end: done_o[owner] pulses for the next cycle and period_cnt increments.
  - If period_cnt == PERIODS_PER_GRANT-1 at a period end, go to RELEASE.
  - If req_i[owner]==0 in any RUN cycle, abort: go to RELEASE with no done pulse. Abort takes priority over a simultaneous period end.
- RELEASE:
  - One cycle with gnt_o=0 and busy_o=0; last_owner=owner.
  - Then go to IDLE.
  - New arbitration happens no earlier than the IDLE cycle, so there are 2 dead cycles between owners.
- Period length is 2^WIDTH - val cycles. val = all-ones gives 1-cycle periods, with done on every RUN cycle.
- req_val_i changes after capture are ignored until the next grant.
- Requests from non-owners during RUN are only queued: they are observed in IDLE and do not preempt.
- Reset during RUN or LOAD: outputs clear immediately. The counter's content is not restored; the next grant reloads it.

Test Plan:
- Defaults apply to every scenario. Single requester: req_i=0001 (req 0), val0=0xA held from t0.
  - Required: gnt_o=0001 and ctr_load_o=1 with 0xA for one cycle (LOAD).
  - done_o[0] pulses after 6 RUN cycles (A..F), then again 6 cycles later.
  - After the second pulse: one RELEASE cycle with gnt_o=0, then IDLE, then re-grant of requester 0.
- Round-robin: req_i=0101 held, val0=0xC, val2=0xE.
  - Required grant order 0,2,0,2; each grant gives two done pulses (4-cycle and 2-cycle periods).
  - ctr_load_val_o alternates 0xC and 0xE.
- Abort: requester 1, val=0x8. Drop req_i[1] 3 cycles into RUN.
  - Required: no done pulse; gnt_o=0 within 1 edge; queued requester 3 is granted via IDLE.
- Boundary value: val=0xF.
  - Required: done_o pulses on two consecutive cycles, then release.
- Value change ignored: change val0 from 0xA to 0x2 mid-RUN.
  - Required: periods stay 6 cycles; 0x2 is used only at the next grant.
- Async reset mid-RUN with req_i=1001.
  - Required: all outputs 0 immediately on reset low.
  - After reset is released, requester 0 is granted before requester 3.
